// File: rtl/reg8_share_pkg.sv
// rtl/reg8_share_pkg.sv - shared types and round-robin helpers for reg8_share_ctrl
package reg8_share_pkg;

    localparam int MAX_REQ = 8;
    localparam int ST_W    = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        ACK   = 3'd2,
        CLEAR = 3'd3,
        CACK  = 3'd4
    } state_t;

    // First set request bit scanning ptr, ptr+1, .. mod n; -1 when none is set.
    function automatic int rr_first(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
        int r;
        int j;
        r = -1;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = (ptr + k) % n;
                if (req[j[2:0]]) begin
                    r = j;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot8(input int idx);
        logic [MAX_REQ-1:0] r;
        r = '0;
        r[idx[2:0]] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/reg8_share_ctrl_rr_pick.sv
// rtl/reg8_share_ctrl_rr_pick.sv - combinational round-robin picker
module rr_pick
    import reg8_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    int first;

    // Winner is the first requester at or after the pointer, wrapping around.
    always_comb begin
        first  = rr_first(MAX_REQ'(req), int'(ptr), N_REQ);
        valid  = (first >= 0);
        idx    = valid ? PTR_W'(first) : '0;
        onehot = valid ? N_REQ'(onehot8(first)) : '0;
    end

endmodule

// File: rtl/reg8_share_ctrl.sv
// rtl/reg8_share_ctrl.sv - round-robin write/clear sequencer for one shared enable-gated register
module reg8_share_ctrl
    import reg8_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   CK,
    input  logic                   CLR,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    input  logic                   clr_req,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   clr_ack,
    output logic                   busy,
    output logic [WIDTH-1:0]       reg_d,
    output logic                   reg_en_n,
    output logic                   reg_clr_n
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t             state, n_state;
    logic [PTR_W-1:0]   ptr, n_ptr;
    logic [PTR_W-1:0]   win_idx, n_win_idx;
    logic [N_REQ-1:0]   n_gnt, n_ack;
    logic               n_clr_ack, n_reg_en_n;
    logic [WIDTH-1:0]   n_reg_d;
    logic               clr_q_n, n_clr_q_n;

    logic [N_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // The register clears with the block reset as well as on a serviced clear request.
    assign reg_clr_n = CLR & clr_q_n;

    // State and every registered output; CLR abandons any operation in flight.
    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            state    <= IDLE;
            ptr      <= '0;
            win_idx  <= '0;
            gnt      <= '0;
            ack      <= '0;
            clr_ack  <= 1'b0;
            busy     <= 1'b0;
            reg_d    <= '0;
            reg_en_n <= 1'b1;
            clr_q_n  <= 1'b1;
        end else begin
            state    <= n_state;
            ptr      <= n_ptr;
            win_idx  <= n_win_idx;
            gnt      <= n_gnt;
            ack      <= n_ack;
            clr_ack  <= n_clr_ack;
            busy     <= (n_state != IDLE);
            reg_d    <= n_reg_d;
            reg_en_n <= n_reg_en_n;
            clr_q_n  <= n_clr_q_n;
        end
    end

    // Next state and next registered outputs; clear requests win over writes.
    always_comb begin
        n_state    = state;
        n_ptr      = ptr;
        n_win_idx  = win_idx;
        n_gnt      = '0;
        n_ack      = '0;
        n_clr_ack  = 1'b0;
        n_reg_d    = reg_d;
        n_reg_en_n = 1'b1;
        n_clr_q_n  = 1'b1;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    n_state   = CLEAR;
                    n_clr_q_n = 1'b0;
                end else if (pick_valid) begin
                    n_state    = WRITE;
                    n_gnt      = pick_onehot;
                    n_win_idx  = pick_idx;
                    n_reg_d    = wdata[int'(pick_idx)*WIDTH +: WIDTH];
                    n_reg_en_n = 1'b0;
                end
            end
            WRITE: begin
                n_state = ACK;
                n_ack   = gnt;
                n_ptr   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            ACK: begin
                n_state = IDLE;
            end
            CLEAR: begin
                n_state   = CACK;
                n_clr_ack = 1'b1;
            end
            CACK: begin
                n_state = IDLE;
            end
            default: begin
                n_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg8_share_ctrl.sv
// tb/tb_reg8_share_ctrl.sv - self-checking bench for reg8_share_ctrl
module tb_reg8_share_ctrl;

    localparam int N = 4;
    localparam int W = 8;

    logic           CK;
    logic           CLR;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic           clr_req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           clr_ack;
    logic           busy;
    logic [W-1:0]   reg_d;
    logic           reg_en_n;
    logic           reg_clr_n;

    int checks   = 0;
    int failures = 0;

    reg8_share_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
        .CK        (CK),
        .CLR       (CLR),
        .req       (req),
        .wdata     (wdata),
        .clr_req   (clr_req),
        .gnt       (gnt),
        .ack       (ack),
        .clr_ack   (clr_ack),
        .busy      (busy),
        .reg_d     (reg_d),
        .reg_en_n  (reg_en_n),
        .reg_clr_n (reg_clr_n)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // The shared enable-gated register the block controls.
    logic [W-1:0] shared_q;
    always @(posedge CK or negedge reg_clr_n) begin
        if (!reg_clr_n) shared_q <= '0;
        else if (!reg_en_n) shared_q <= reg_d;
    end

    // Transaction model: phase 0 idle, 1 writing, 2 acking, 3 clearing, 4 clear-acking.
    int         m_phase;
    int         m_ptr;
    int         m_win;
    logic [7:0] m_data;
    logic [7:0] m_q;

    always @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            m_phase = 0;
            m_ptr   = 0;
            m_win   = 0;
            m_data  = 8'h00;
            m_q     = 8'h00;
        end else begin
            case (m_phase)
                0: begin
                    if (clr_req) begin
                        m_phase = 3;
                        m_q     = 8'h00;
                    end else if (req != 0) begin
                        for (int k = N - 1; k >= 0; k--) begin
                            if (req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
                        end
                        m_data  = wdata[m_win*W +: W];
                        m_phase = 1;
                    end
                end
                1: begin
                    m_q     = m_data;
                    m_ptr   = (m_win + 1) % N;
                    m_phase = 2;
                end
                3: m_phase = 4;
                default: m_phase = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge CK) begin
        chk("m_gnt",      32'(gnt),       (m_phase == 1) ? (32'd1 << m_win) : 32'd0);
        chk("m_ack",      32'(ack),       (m_phase == 2) ? (32'd1 << m_win) : 32'd0);
        chk("m_clr_ack",  32'(clr_ack),   32'(m_phase == 4));
        chk("m_busy",     32'(busy),      32'(m_phase != 0));
        chk("m_reg_en_n", 32'(reg_en_n),  32'(m_phase != 1));
        chk("m_reg_clr_n",32'(reg_clr_n), 32'(CLR && (m_phase != 3)));
        chk("m_q",        32'(shared_q),  32'(m_q));
        if (m_phase == 1) chk("m_reg_d", 32'(reg_d), 32'(m_data));
    end

    int grants[$];

    // Advance to the next falling edge; requesters drop their request once acknowledged.
    task automatic step();
        @(negedge CK);
        if (gnt != 0) begin
            for (int i = 0; i < N; i++) if (gnt[i]) grants.push_back(i);
        end
        for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
        if (clr_ack) clr_req = 1'b0;
    endtask

    task automatic run_until_idle(input string name);
        int budget;
        budget = 40;
        while ((req != 0 || clr_req || busy) && budget > 0) begin
            step();
            budget--;
        end
        chk({name, "_timeout"}, 32'(budget == 0), 32'd0);
    endtask

    initial begin
        CLR = 1'b0; req = '0; wdata = '0; clr_req = 1'b0;
        step(); step();
        chk("rst_gnt",       32'(gnt),       32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_reg_en_n",  32'(reg_en_n),  32'd1);
        chk("rst_reg_clr_n", 32'(reg_clr_n), 32'd0);
        chk("rst_reg_d",     32'(reg_d),     32'd0);
        CLR = 1'b1;
        step();

        // Single write from requester 0.
        wdata[0*W +: W] = 8'hA5; req = 4'b0001;
        step();
        chk("t2_gnt",      32'(gnt),      32'h1);
        chk("t2_reg_en_n", 32'(reg_en_n), 32'd0);
        step();
        chk("t2_q",        32'(shared_q), 32'hA5);
        chk("t2_ack",      32'(ack),      32'h1);
        run_until_idle("t2");

        // Reset pulse in the middle of a write.
        wdata[1*W +: W] = 8'h77; req = 4'b0010;
        step();
        chk("t1_gnt_pre", 32'(gnt), 32'h2);
        #2 CLR = 1'b0;
        #1;
        chk("t1_gnt",       32'(gnt),       32'd0);
        chk("t1_reg_en_n",  32'(reg_en_n),  32'd1);
        chk("t1_reg_clr_n", 32'(reg_clr_n), 32'd0);
        chk("t1_busy",      32'(busy),      32'd0);
        req = '0;
        step(); step();
        CLR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_no_ack", 32'(ack), 32'd0);
        end

        // All four requesting: order 0..3, then wrap back to 0.
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        grants.delete();
        req = 4'b1111;
        run_until_idle("t3a");
        req = 4'b1111;
        run_until_idle("t3b");
        chk("t3_count", 32'(grants.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grants.size()) chk("t3_order", 32'(grants[i]), 32'(i % 4));
        end
        chk("t3_q", 32'(shared_q), 32'h44);

        // Clear and write requested together: clear first.
        wdata[2*W +: W] = 8'h5A; req = 4'b0100; clr_req = 1'b1;
        step();
        chk("t4_reg_clr_n", 32'(reg_clr_n), 32'd0);
        chk("t4_gnt",       32'(gnt),       32'd0);
        step();
        chk("t4_clr_ack",   32'(clr_ack),   32'd1);
        chk("t4_q_zero",    32'(shared_q),  32'h00);
        chk("t4_clr_n_up",  32'(reg_clr_n), 32'd1);
        step(); step();
        chk("t4_gnt2",      32'(gnt),       32'h4);
        run_until_idle("t4");
        chk("t4_q",         32'(shared_q),  32'h5A);

        // Data change during WRITE is ignored.
        wdata[1*W +: W] = 8'h3C; req = 4'b0010;
        step();
        chk("t5_gnt", 32'(gnt), 32'h2);
        wdata[1*W +: W] = 8'hFF;
        step();
        chk("t5_q",   32'(shared_q), 32'h3C);
        run_until_idle("t5");

        // Request glitch between edges is never sampled.
        req = 4'b1000;
        #2 req = 4'b0000;
        step();
        chk("t6_gnt",  32'(gnt),      32'd0);
        chk("t6_busy", 32'(busy),     32'd0);
        step();
        chk("t6_ack",  32'(ack),      32'd0);
        chk("t6_q",    32'(shared_q), 32'h3C);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
